// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents: RV32I funct3 codes, FSM state enum, latched access descriptor,
//           access size / byte-mask / funct3-legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Access attributes carried from accept into the ACCESS cycle
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic       fault;
  } lsu_acc_t;

  // Access width in bytes from funct3[1:0]; code 3 is illegal and faults elsewhere
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] bmask_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Loads accept LB/LH/LW/LBU/LHU, stores accept SB/SH/SW
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 < 3'd3);
    return (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake bundle between a requester and lsu_ctrl.
// slave  : the LSU side (consumes requests, produces responses)
// master : the requester side
interface lsu_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load-data extender.
// funct3 : load type (LB/LH/LW/LBU/LHU)
// rdata  : raw little-endian word from memory, access starts at byte 0
// ext_c  : sign/zero-extended result
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ext_c
);

  always_comb begin
    ext_c = rdata;
    case (funct3)
      F3_LB:   ext_c = {{24{rdata[7]}}, rdata[7:0]};
      F3_LH:   ext_c = {{16{rdata[15]}}, rdata[15:0]};
      F3_LBU:  ext_c = {24'd0, rdata[7:0]};
      F3_LHU:  ext_c = {16'd0, rdata[15:0]};
      default: ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a byte-addressable data memory.
// Accepts RV32I loads/stores, checks funct3 legality and range, drives the
// memory for exactly the ACCESS cycle and returns a registered response.
// Ports: i_clk, i_reset (async active-low), bus (lsu_ctrl_if.slave),
//        o_mem_addr/o_mem_bmask/o_mem_wdata/o_mem_wren, i_mem_rdata (comb).
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses; otherwise misaligned accesses go to the byte-granular memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  lsu_ctrl_if.slave                    bus,
  output logic [$clog2(MEM_BYTES)-1:0] o_mem_addr,
  output logic [3:0]                   o_mem_bmask,
  output logic [31:0]                  o_mem_wdata,
  output logic                         o_mem_wren,
  input  logic [31:0]                  i_mem_rdata
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  lsu_state_e    state_q, state_d;
  logic          req_ready_c, req_hs_c, rsp_hs_c;
  logic [31:0]   offset_c;
  logic          range_err_c, misalign_c, fault_c;
  logic [31:0]   ext_c;
  lsu_acc_t      acc_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_bmask_q;
  logic [31:0]   mem_wdata_q;
  logic          mem_wren_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake decode
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    rsp_hs_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.i_req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        req_ready_c = bus.i_rsp_ready;
        if (bus.i_rsp_ready) begin
          rsp_hs_c = 1'b1;
          state_d  = bus.i_req_valid ? ST_ACCESS : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_hs_c = bus.i_req_valid && req_ready_c;

  // Fault check on the incoming request; 33-bit end address so wrapped offsets fail
  assign offset_c    = bus.i_req_addr - BASE_ADDR;
  assign range_err_c = ({1'b0, offset_c} + 33'(size_bytes(bus.i_req_funct3[1:0])))
                       > 33'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c  = ((bus.i_req_funct3[1:0] == 2'd1) && offset_c[0]) ||
                       ((bus.i_req_funct3[1:0] == 2'd2) && (offset_c[1:0] != 2'd0));
`else
  assign misalign_c  = 1'b0;
`endif
  assign fault_c     = !f3_legal(bus.i_req_we, bus.i_req_funct3) || range_err_c || misalign_c;

  lsu_load_ext u_load_ext (
    .funct3 (acc_q.funct3),
    .rdata  (i_mem_rdata),
    .ext_c  (ext_c)
  );

  // Memory-side drive: enables are set on accept and therefore live only in ACCESS
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q       <= '0;
      mem_addr_q  <= '0;
      mem_bmask_q <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
    end else if (req_hs_c) begin
      acc_q       <= '{we: bus.i_req_we, funct3: bus.i_req_funct3, fault: fault_c};
      mem_addr_q  <= offset_c[AW-1:0];
      mem_bmask_q <= bmask_of(bus.i_req_funct3[1:0]);
      mem_wdata_q <= bus.i_req_wdata;
      mem_wren_q  <= bus.i_req_we && !fault_c;
    end else begin
      mem_bmask_q <= '0;
      mem_wren_q  <= 1'b0;
    end
  end

  // Response register: loaded at the end of ACCESS, held until consumed
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= acc_q.fault;
      rsp_rdata_q <= (acc_q.fault || acc_q.we) ? 32'd0 : ext_c;
    end else if (rsp_hs_c) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.o_req_ready = req_ready_c;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_bmask     = mem_bmask_q;
  assign o_mem_wdata     = mem_wdata_q;
  assign o_mem_wren      = mem_wren_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed scenarios plus random traffic,
// checked against a byte-array reference model of the memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int unsigned MEM_BYTES = 2048;
  localparam logic [31:0] BASE      = 32'h0000_2000;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [10:0] addr; logic [3:0] bmask; logic [31:0] wdata; } wr_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 i_clk = ~i_clk;

  lsu_ctrl_if bus ();
  logic [10:0] mem_addr;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_wren;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .bus         (bus),
    .o_mem_addr  (mem_addr),
    .o_mem_bmask (mem_bmask),
    .o_mem_wdata (mem_wdata),
    .o_mem_wren  (mem_wren),
    .i_mem_rdata (mem_rdata)
  );

  int total = 0;
  int bad = 0;
  int wren_cycles = 0;
  rsp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] mem[MEM_BYTES];
  logic [7:0] ref_mem[MEM_BYTES];
  logic mem_inited = 1'b0;
  logic rdy_hold = 1'b0;
  logic rdy_val = 1'b0;
  logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Memory device: combinational read, byte-masked write on the clock edge
  always_comb begin
    int a;
    a = int'(mem_addr);
    mem_rdata = {mem[(a + 3) % MEM_BYTES], mem[(a + 2) % MEM_BYTES],
                 mem[(a + 1) % MEM_BYTES], mem[a]};
  end

  always @(posedge i_clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= pat(i);
      mem_inited <= 1'b1;
    end else if (mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (mem_bmask[i]) mem[(int'(mem_addr) + i) % MEM_BYTES] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what a single access should do, from the access rules alone
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int unsigned off;
    int size;
    logic err;
    longint v;
    off  = addr - BASE;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (longint'(off) + longint'(size) > longint'(MEM_BYTES)) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size > 1 && (off % size) != 0) err = 1'b1;
`endif
    if (err) begin
      exp_q.push_back('{rdata: 32'd0, err: 1'b1});
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[off + i] = wdata[8*i +: 8];
      exp_q.push_back('{rdata: 32'd0, err: 1'b0});
      wr_q.push_back('{addr: 11'(off), bmask: 4'((1 << size) - 1), wdata: wdata});
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[off + i]) << (8 * i);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v -= (longint'(1) << (8 * size));
      exp_q.push_back('{rdata: 32'(v), err: 1'b0});
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n;
    n = 0;
    @(posedge i_clk);
    #1;
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
    @(negedge i_clk);
    while (!bus.o_req_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.o_req_ready) begin
      total++;
      bad++;
      $display("FAIL req_accept_timeout: got ready=0 expected ready=1 addr=%h", addr);
    end else begin
      model(we, f3, addr, wdata);
    end
    @(posedge i_clk);
    #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    rdy_hold = 1'b1;
    rdy_val  = 1'b1;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    chk(name, 32'(exp_q.size() + wr_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, bus.o_rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(bus.o_rsp_err), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_bmask"}, 32'(mem_bmask), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wren"},  32'(mem_wren), 32'd0);
  endtask

  // Response-ready driver
  initial begin
    bus.i_rsp_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      bus.i_rsp_ready = rdy_hold ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare presented responses and memory writes against the model queues
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        if (bus.o_rsp_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rdata=%h err=%0b expected no response",
                     bus.o_rsp_rdata, bus.o_rsp_err);
          end else begin
            chk("rsp_rdata", bus.o_rsp_rdata, exp_q[0].rdata);
            chk("rsp_err", 32'(bus.o_rsp_err), 32'(exp_q[0].err));
            chk("resp_mem_quiet", {27'd0, mem_wren, mem_bmask}, 32'd0);
            if (bus.i_rsp_ready) void'(exp_q.pop_front());
          end
        end
        if (mem_wren) begin
          wren_cycles++;
          if (wr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wren_unexpected: got wren=1 addr=%h expected wren=0", mem_addr);
          end else begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_q[0].addr));
            chk("wr_bmask", 32'(mem_bmask), 32'(wr_q[0].bmask));
            chk("wr_wdata", mem_wdata, wr_q[0].wdata);
            void'(wr_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, diffs;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'd0;
    bus.i_req_addr   = 32'd0;
    bus.i_req_wdata  = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge i_clk);
    #2;
    chk_reset_outputs("reset");
    @(negedge i_clk);
    i_reset = 1'b1;

    // Store then load a word; the store must pulse wren for one cycle
    w0 = wren_cycles;
    do_req(1'b1, F3_SW, BASE + 32'h10, 32'hDEAD_BEEF);
    do_req(1'b0, F3_LW, BASE + 32'h10, 32'd0);
    wait_drain("drain_sw_lw");
    chk("sw_wren_cycles", 32'(wren_cycles - w0), 32'd1);
    rdy_hold = 1'b0;

    // Sign/zero extension
    do_req(1'b1, F3_SB, BASE + 32'h10, 32'h0000_0080);
    do_req(1'b0, F3_LB, BASE + 32'h10, 32'd0);
    do_req(1'b0, F3_LBU, BASE + 32'h10, 32'd0);
    do_req(1'b1, F3_SH, BASE + 32'h10, 32'h0000_8001);
    do_req(1'b0, F3_LH, BASE + 32'h10, 32'd0);
    do_req(1'b0, F3_LHU, BASE + 32'h10, 32'd0);

    // Range and funct3 faults
    do_req(1'b0, F3_LW, BASE + MEM_BYTES - 2, 32'd0);
    do_req(1'b1, F3_SW, BASE + MEM_BYTES - 2, 32'h1234_5678);
    do_req(1'b0, F3_LW, 32'h0000_0000, 32'd0);
    do_req(1'b0, F3_LW, 32'hFFFF_FFFE, 32'd0);
    do_req(1'b0, 3'd3, BASE + 32'h20, 32'd0);
    do_req(1'b0, 3'd6, BASE + 32'h20, 32'd0);
    do_req(1'b1, 3'd3, BASE + 32'h20, 32'hFFFF_FFFF);
    do_req(1'b1, F3_SB, BASE + MEM_BYTES - 1, 32'h0000_00A5);
    do_req(1'b0, F3_LBU, BASE + MEM_BYTES - 1, 32'd0);
    wait_drain("drain_faults");

    // Response back-pressure, then back-to-back accept out of RESP
    rdy_val = 1'b0;
    do_req(1'b0, F3_LW, BASE + 32'h10, 32'd0);
    fork
      do_req(1'b0, F3_LW, BASE + 32'h20, 32'd0);
      begin
        @(posedge i_clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge i_clk);
          chk("hold_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
          chk("hold_req_ready", 32'(bus.o_req_ready), 32'd0);
        end
        rdy_val = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("b2b_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("b2b_access_bmask", 32'(mem_bmask), 32'hF);
      end
    join
    wait_drain("drain_b2b");
    rdy_hold = 1'b0;

    // Misaligned halfword
    do_req(1'b0, F3_LH, BASE + 32'h11, 32'd0);
    do_req(1'b1, F3_SW, BASE + 32'h31, 32'h0BAD_F00D);
    do_req(1'b0, F3_LW, BASE + 32'h30, 32'd0);
    wait_drain("drain_misalign");

    // Reset while a store is in ACCESS: no write may land
    @(posedge i_clk);
    #1;
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = 1'b1;
    bus.i_req_funct3 = F3_SW;
    bus.i_req_addr   = BASE + 32'h40;
    bus.i_req_wdata  = 32'h1234_5678;
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++)
      chk("midreset_mem_byte", 32'(mem[16'h40 + i]), 32'(ref_mem[16'h40 + i]));

    // Random traffic
    rdy_hold = 1'b0;
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = BASE + MEM_BYTES - 32'($urandom_range(0, 4));
        default: addr = BASE + 32'($urandom_range(0, MEM_BYTES - 1));
      endcase
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'd0;
      do_req(we, f3, addr, $urandom);
    end
    wait_drain("drain_random");

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
